id_ex_stage: RTL

- Decode-to-execute pipeline stage directly downstream of register_file.
- Captures readData1/readData2, register indices, immediate and control bundle into the ID/EX pipeline register.
- Detects load-use hazards and inserts one bubble per hazard.
- Honours a downstream hold and a branch flush.
- Optionally bypasses the same-cycle writeback value, because register_file commits writes on the clock edge and reads stale data in that cycle.

---
 rtl/id_ex_stage_if.sv | 42 ++++
 rtl/id_ex_stage.sv | 84 ++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// Bundle of decode-slot, writeback, control and ID/EX result signals around id_ex_stage.
// The master modport is the surrounding pipeline; the slave modport is the stage itself.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 10
);
    logic              id_valid;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              flush;
    logic              hold;
    logic              wb_regWrite;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic              ex_valid;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic [DATA_W-1:0] ex_rdata1;
    logic [DATA_W-1:0] ex_rdata2;
    logic [DATA_W-1:0] ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              stall;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_ctrl,
        output flush, hold, wb_regWrite, wb_rd, wb_data,
        input  ex_valid, ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_ctrl, stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_ctrl,
        input  flush, hold, wb_regWrite, wb_rd, wb_data,
        output ex_valid, ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_ctrl, stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold and flush.
// Define ID_EX_WB_BYPASS_EN to forward the same-cycle writeback value into the operands.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 10
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    localparam int CTRL_MEMREAD = 1;

    typedef struct packed {
        logic              valid;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    ex_t  ex_q;
    ex_t  ex_d;
    logic luh;

    // A load in EX whose target is read by the decode slot must wait one cycle.
    assign luh = ex_q.valid & ex_q.ctrl[CTRL_MEMREAD] & (ex_q.rt != 5'd0) & bus.id_valid
               & ((bus.id_rs == ex_q.rt) | (bus.id_rt == ex_q.rt));

    assign bus.stall = rst_n & (bus.hold | luh);

`ifdef ID_EX_WB_BYPASS_EN
    function automatic logic wb_hits(input logic we, input logic [4:0] wrd, input logic [4:0] idx);
        return we & (wrd != 5'd0) & (wrd == idx);
    endfunction
`endif

    // NOTE: every field of ex_d gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d.valid = 1'b0;
            ex_d.ctrl  = '0;
        end else if (bus.hold) begin
`ifdef ID_EX_WB_BYPASS_EN
            if (wb_hits(bus.wb_regWrite, bus.wb_rd, ex_q.rs)) ex_d.rdata1 = bus.wb_data;
            if (wb_hits(bus.wb_regWrite, bus.wb_rd, ex_q.rt)) ex_d.rdata2 = bus.wb_data;
`endif
        end else if (luh) begin
            ex_d.valid = 1'b0;
            ex_d.ctrl  = '0;
        end else begin
            ex_d.valid  = bus.id_valid;
            ex_d.ctrl   = bus.id_valid ? bus.id_ctrl : '0;
            ex_d.rs     = bus.id_rs;
            ex_d.rt     = bus.id_rt;
            ex_d.rd     = bus.id_rd;
            ex_d.rdata1 = bus.id_rdata1;
            ex_d.rdata2 = bus.id_rdata2;
            ex_d.imm    = bus.id_imm;
`ifdef ID_EX_WB_BYPASS_EN
            if (wb_hits(bus.wb_regWrite, bus.wb_rd, bus.id_rs)) ex_d.rdata1 = bus.wb_data;
            if (wb_hits(bus.wb_regWrite, bus.wb_rd, bus.id_rt)) ex_d.rdata2 = bus.wb_data;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign bus.ex_valid  = ex_q.valid;
    assign bus.ex_rs     = ex_q.rs;
    assign bus.ex_rt     = ex_q.rt;
    assign bus.ex_rd     = ex_q.rd;
    assign bus.ex_rdata1 = ex_q.rdata1;
    assign bus.ex_rdata2 = ex_q.rdata2;
    assign bus.ex_imm    = ex_q.imm;
    assign bus.ex_ctrl   = ex_q.ctrl;
endmodule
